// File: rtl/rtc_read_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtc_pkg
// Brief    : Shared constants and types for the RTC read sequencer: command
//            write address/value, address map of the nine polled registers,
//            hour-field mask and the sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  // Transfer command that latches the RTC time registers before reading
  localparam logic [7:0] CMD_ADDR  = 8'hF0;
  localparam logic [7:0] CMD_XFER  = 8'hF2;

  // Number of register reads per burst and the slots that hold hour fields
  localparam logic [3:0] NUM_READS  = 4'd9;
  localparam logic [3:0] IDX_HORA   = 4'd2;
  localparam logic [3:0] IDX_HORACR = 4'd8;

  // Hour bytes carry the 12/24h and AM/PM flags in the top bits
  localparam logic [7:0] HOUR_MASK = 8'h3F;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    RD     = 3'd2,
    GAP    = 3'd3,
    COMMIT = 3'd4,
    ABORT  = 3'd5
  } state_t;

  // Address ROM: read slot index -> RTC register address
  function automatic logic [7:0] read_addr(input logic [3:0] idx);
    logic [7:0] a;
    a = 8'h00;
    case (idx)
      4'd0:    a = 8'h21;  // seg
      4'd1:    a = 8'h22;  // min
      4'd2:    a = 8'h23;  // hora
      4'd3:    a = 8'h24;  // dia
      4'd4:    a = 8'h25;  // mes
      4'd5:    a = 8'h26;  // year
      4'd6:    a = 8'h41;  // segcr
      4'd7:    a = 8'h42;  // mincr
      4'd8:    a = 8'h43;  // horacr
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_poll_timer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_poll_timer
// Brief    : Free-running down counter that produces a one-cycle expiry
//            pulse every POLL_CYCLES cycles while enabled.
// Revision : 1.0 - initial release
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            en     - count enable; counter holds while low
//            expiry - high for the cycle in which the count wraps
// ============================================================================
module rtc_poll_timer #(
  parameter int unsigned POLL_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expiry
);

  localparam int unsigned     c_cw     = $clog2(POLL_CYCLES);
  localparam logic [c_cw-1:0] c_reload = c_cw'(POLL_CYCLES - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= c_reload;
    end else if (en) begin
      if (r_cnt == '0) r_cnt <= c_reload;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  // Combinational so the sequencer reacts in the wrap cycle itself
  assign expiry = en && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_read_seq.sv
`default_nettype none
// ============================================================================
// Module   : rtc_read_seq
// Brief    : Periodic / on-demand RTC read sequencer. Issues the transfer
//            command, reads nine time/date/timer registers into shadow
//            registers and publishes them atomically as three BCD words.
// Revision : 1.0 - initial release
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            en, refresh        - poll enable, immediate burst request
//            bus_req/wr/addr/wdata, bus_ack/rdata - RTC bus handshake
//            datos1..3, ap      - published time, date, timer, PM flag
//            valid, busy, err   - update strobe, burst active, sticky timeout
// ============================================================================
module rtc_read_seq
  import rtc_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = 10_000_000,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        refresh,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic [23:0] datos1,
  output logic [23:0] datos2,
  output logic [23:0] datos3,
  output logic        ap,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  // Last wait-count value; an ack arriving in that same cycle still wins
  localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_idx;
  logic [7:0] r_wcnt;
  logic       r_pending;
  logic [7:0] r_shadow [NUM_READS];
  logic       r_ap_sh;

  logic w_expiry;
  logic w_trigger;
  logic w_ack;
  logic w_timeout;

  rtc_poll_timer #(
    .POLL_CYCLES (POLL_CYCLES)
  ) u_poll_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .expiry (w_expiry)
  );

  assign w_trigger = w_expiry || refresh || r_pending;
  assign w_ack     = bus_ack && bus_req;
  assign w_timeout = (r_wcnt == c_to_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_pending <= 1'b0;
      r_ap_sh   <= 1'b0;
      for (int i = 0; i < int'(NUM_READS); i++) r_shadow[i] <= '0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      datos1    <= '0;
      datos2    <= '0;
      datos3    <= '0;
      ap        <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_state   <= CMD;
            r_idx     <= '0;
            r_wcnt    <= '0;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b1;
            bus_addr  <= CMD_ADDR;
            bus_wdata <= CMD_XFER;
            busy      <= 1'b1;
          end
        end

        CMD, RD: begin
          if (w_ack) begin
            bus_req <= 1'b0;
            r_state <= GAP;
            if (r_state == RD) begin
              if (r_idx == IDX_HORA || r_idx == IDX_HORACR)
                r_shadow[r_idx] <= bus_rdata & HOUR_MASK;
              else
                r_shadow[r_idx] <= bus_rdata;
              if (r_idx == IDX_HORA) r_ap_sh <= bus_rdata[7];
              r_idx <= r_idx + 1'b1;
            end
          end else if (w_timeout) begin
            bus_req <= 1'b0;
            err     <= 1'b1;
            r_state <= ABORT;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end

        GAP: begin
          if (r_idx < NUM_READS) begin
            r_state   <= RD;
            r_wcnt    <= '0;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_addr  <= read_addr(r_idx);
            bus_wdata <= '0;
          end else begin
            r_state <= COMMIT;
          end
        end

        COMMIT: begin
          datos1  <= {r_shadow[2], r_shadow[1], r_shadow[0]};
          datos2  <= {r_shadow[3], r_shadow[4], r_shadow[5]};
          datos3  <= {r_shadow[8], r_shadow[7], r_shadow[6]};
          ap      <= r_ap_sh;
          valid   <= 1'b1;
          err     <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        ABORT: begin
          // Partial burst is dropped so a later commit never mixes bursts
          for (int i = 0; i < int'(NUM_READS); i++) r_shadow[i] <= '0;
          r_ap_sh <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase

      // Any trigger seen in IDLE starts a burst at once, so pending only
      // needs to remember triggers that arrive while a burst is in flight.
      if (r_state == IDLE)
        r_pending <= 1'b0;
      else if (w_expiry || refresh)
        r_pending <= 1'b1;
    end
  end

endmodule
`default_nettype wire
